// File: rtl/turfio_uart_rx_if.sv
// Byte stream from the UART receiver: single-entry AXI4-Stream style handshake.
interface turfio_uart_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/turfio_uart_rx.sv
// 16x-oversampled 8N1 UART receiver with fractional-accumulator tick generator.
// Optional 2-of-3 sample voting is enabled by defining UART_RX_MAJORITY_EN.
module turfio_uart_rx #(
    parameter int unsigned TICK_ADD    = 82,
    parameter int unsigned TICK_BITS   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_i,
    turfio_uart_rx_if.master        m_axis,
    output logic                    frame_err_o,
    output logic                    overrun_o,
    output logic                    busy_o,
    output logic                    tick_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    logic [TICK_BITS:0]   acc;
    logic                 tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic                 sample;

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [2:0]           idx, idx_nxt;
    logic [7:0]           shreg, shreg_nxt;

    logic                 deliver, bad_stop;
    logic [7:0]           tdata_q;
    logic                 tvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[TICK_BITS-1:0]} + (TICK_BITS+1)'(TICK_ADD);
        end
    end

    assign tick   = acc[TICK_BITS];
    assign tick_o = tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // Vote over the ticks at cnt-1, cnt, cnt+1; the decision lands one tick later,
    // so entering DATA one tick late keeps the cnt==15 compare on the vote tick.
    localparam logic [3:0] START_CHK = 4'd8;
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '1;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    localparam logic [3:0] START_CHK = 4'd7;
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (cnt == START_CHK) begin
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = sample ? IDLE : DATA;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt == 4'd15) begin
                        shreg_nxt = {sample, shreg[7:1]};
                        cnt_nxt   = '0;
                        idx_nxt   = idx + 3'd1;
                        if (idx == 3'd7) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (cnt == 4'd15) begin
                        cnt_nxt   = '0;
                        state_nxt = sample ? IDLE : BRK;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o   = (state != IDLE);
        deliver  = 1'b0;
        bad_stop = 1'b0;
        if (tick && state == STOP && cnt == 4'd15) begin
            deliver  = sample;
            bad_stop = !sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= bad_stop;
            overrun_o   <= deliver && tvalid_q && !m_axis.tready;
            if (deliver) begin
                if (!tvalid_q || m_axis.tready) begin
                    tdata_q  <= shreg;
                    tvalid_q <= 1'b1;
                end
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_turfio_uart_rx.sv
// Self-checking bench for turfio_uart_rx: fast-tick instance for frame/handshake cases,
// default-parameter instance for baud tolerance (and vote glitch when UART_RX_MAJORITY_EN).
module tb_turfio_uart_rx;

    localparam int BIT_CLK = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rx, rxd;
    logic ferr, ovr, busy, tick;
    logic ferr_d, ovr_d, busy_d, tick_d;

    turfio_uart_rx_if axs ();
    turfio_uart_rx_if axd ();

    turfio_uart_rx #(.TICK_ADD(512), .TICK_BITS(10), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx), .m_axis(axs),
        .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy), .tick_o(tick)
    );

    turfio_uart_rx dut_d (
        .clk(clk), .rst_n(rst_n), .rx_i(rxd), .m_axis(axd),
        .frame_err_o(ferr_d), .overrun_o(ovr_d), .busy_o(busy_d), .tick_o(tick_d)
    );

    int vectors = 0;
    int miscompares = 0;
    int ferr_cnt = 0, ovr_cnt = 0, ferrd_cnt = 0, ovrd_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] gotd_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (axs.tvalid && axs.tready) got_q.push_back(axs.tdata);
        if (axd.tvalid && axd.tready) gotd_q.push_back(axd.tdata);
        if (ferr) ferr_cnt++;
        if (ovr) ovr_cnt++;
        if (ferr_d) ferrd_cnt++;
        if (ovr_d) ovrd_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear();
        got_q.delete();
        gotd_q.delete();
        ferr_cnt = 0; ovr_cnt = 0; ferrd_cnt = 0; ovrd_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        clks(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(BIT_CLK);
        end
        rx = stop;
        clks(BIT_CLK);
    endtask

    task automatic send_d(input logic [7:0] b, input int bt, input int glitch_bit);
        rxd = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == glitch_bit) begin
                #(bt / 2);
                rxd = ~b[i];
                #10;
                rxd = b[i];
                #(bt - bt / 2 - 10);
            end else begin
                #(bt);
            end
        end
        rxd = 1'b1;
        #(bt);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_beats;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[6];
    int   bauds[2];
    int   n;
    logic saw_busy;
    logic [7:0] b;
    logic bad;
    int   nerr_exp;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 1, 0};
        tbl[3] = '{8'h55, 1'b0, 0, 1};
        tbl[4] = '{8'h3C, 1'b1, 1, 0};
        tbl[5] = '{8'h81, 1'b1, 1, 0};
        bauds[0] = 2062;
        bauds[1] = 1942;

        rst_n = 1'b0;
        rx = 1'b1;
        rxd = 1'b1;
        axs.tready = 1'b1;
        axd.tready = 1'b1;
        clks(3);
        chk("rst_tvalid", axs.tvalid, 0);
        chk("rst_tdata", axs.tdata, 0);
        chk("rst_frame_err", ferr, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        rst_n = 1'b1;
        clks(2 * BIT_CLK);

        for (int i = 0; i < 6; i++) begin
            clear();
            send(tbl[i].data, tbl[i].stop);
            if (tbl[i].stop) chk("busy_after_stop", busy, 0);
            rx = 1'b1;
            clks(2 * BIT_CLK);
            chk("tbl_beats", got_q.size(), tbl[i].exp_beats);
            if (got_q.size() > 0) chk("tbl_tdata", got_q[0], tbl[i].data);
            chk("tbl_frame_err", ferr_cnt, tbl[i].exp_ferr);
            chk("tbl_overrun", ovr_cnt, 0);
            chk("tbl_busy", busy, 0);
        end

        // Short low glitch in IDLE: start rejected at mid-start
        clear();
        rx = 1'b0;
        clks(3);
        rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 36; i++) begin
            clks(1);
            if (busy) saw_busy = 1'b1;
        end
        chk("glitch_started", saw_busy, 1);
        chk("glitch_busy_low", busy, 0);
        chk("glitch_beats", got_q.size(), 0);
        chk("glitch_frame_err", ferr_cnt, 0);

        // Overrun: second byte dropped while first is held
        clear();
        axs.tready = 1'b0;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        clks(BIT_CLK);
        chk("ovr_tvalid_held", axs.tvalid, 1);
        chk("ovr_tdata_held", axs.tdata, 8'h00);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_frame_err", ferr_cnt, 0);
        chk("ovr_no_beat_yet", got_q.size(), 0);
        axs.tready = 1'b1;
        clks(4);
        chk("ovr_beats", got_q.size(), 1);
        if (got_q.size() > 0) chk("ovr_beat_data", got_q[0], 8'h00);
        chk("ovr_tvalid_clear", axs.tvalid, 0);

        // Bad stop followed by a long break: one error pulse only
        clear();
        send(8'h55, 1'b0);
        clks(40 * BIT_CLK);
        rx = 1'b1;
        clks(2 * BIT_CLK);
        chk("brk_frame_err", ferr_cnt, 1);
        chk("brk_beats", got_q.size(), 0);
        chk("brk_overrun", ovr_cnt, 0);
        send(8'h3C, 1'b1);
        clks(BIT_CLK);
        chk("brk_next_beats", got_q.size(), 1);
        if (got_q.size() > 0) chk("brk_next_data", got_q[0], 8'h3C);
        chk("brk_frame_err_after", ferr_cnt, 1);

        // Reset mid-DATA of 0x81
        clear();
        rx = 1'b0;
        clks(BIT_CLK);
        rx = 1'b1; clks(BIT_CLK);
        rx = 1'b0; clks(BIT_CLK);
        rx = 1'b0; clks(BIT_CLK / 2);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        rx = 1'b1;
        clks(2);
        chk("rst_mid_tvalid", axs.tvalid, 0);
        chk("rst_mid_busy", busy, 0);
        clks(5);
        rst_n = 1'b1;
        clks(2 * BIT_CLK);
        send(8'h7E, 1'b1);
        clks(BIT_CLK);
        chk("rst_after_beats", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst_after_data", got_q[0], 8'h7E);
        chk("rst_after_frame_err", ferr_cnt, 0);

        // Random frames against a byte-level model
        clear();
        exp_q.delete();
        nerr_exp = 0;
        for (int k = 0; k < 40; k++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            send(b, !bad);
            rx = 1'b1;
            if (bad) begin
                nerr_exp++;
                clks(BIT_CLK);
            end else begin
                exp_q.push_back(b);
                clks($urandom_range(0, 40));
            end
        end
        clks(2 * BIT_CLK);
        chk("rand_beats", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("rand_data", got_q[i], exp_q[i]);
        end
        chk("rand_frame_err", ferr_cnt, nerr_exp);
        chk("rand_overrun", ovr_cnt, 0);

        // Default parameters: +/-3% baud around 500.5 kbaud
        for (int i = 0; i < 2; i++) begin
            clear();
            send_d(8'hC3, bauds[i], -1);
            #(2 * bauds[i]);
            chk("baud_beats", gotd_q.size(), 1);
            if (gotd_q.size() > 0) chk("baud_data", gotd_q[0], 8'hC3);
            chk("baud_frame_err", ferrd_cnt, 0);
            chk("baud_overrun", ovrd_cnt, 0);
        end

`ifdef UART_RX_MAJORITY_EN
        clear();
        send_d(8'hC3, 1998, 3);
        #(2 * 1998);
        chk("vote_beats", gotd_q.size(), 1);
        if (gotd_q.size() > 0) chk("vote_data", gotd_q[0], 8'hC3);
        chk("vote_frame_err", ferrd_cnt, 0);
`endif

        n = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
